// File: rtl/tessia_mem_pkg.sv
// Shared types and helpers for the CPU-side memory path (store buffer and friends).
package tessia_mem_pkg;

    localparam int SB_WIDTH = 64;

    typedef struct packed {
        logic [SB_WIDTH-1:0] addr;
        logic [SB_WIDTH-1:0] data;
    } sb_entry_t;

    // Word index of a byte address; forwarding matches on whole words only.
    function automatic logic [SB_WIDTH-3:0] word_idx(input logic [SB_WIDTH-1:0] addr);
        return addr[SB_WIDTH-1:2];
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding: compares the load word against every live entry and
// returns the newest matching store data.
module sb_fwd_match
    import tessia_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][SB_WIDTH-1:0] ent_addr,
    input  logic [DEPTH-1:0][SB_WIDTH-1:0] ent_data,
    input  logic [PTR_W-1:0]               head,
    input  logic [PTR_W:0]                 count,
    input  logic [SB_WIDTH-1:0]            ld_addr,
    output logic                           hit,
    output logic [SB_WIDTH-1:0]            data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to newest so a later hit overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (((PTR_W + 1)'(k) < count) && (word_idx(ent_addr[idx]) == word_idx(ld_addr))) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and a single-ported DataMemory:
// loads get the port first, stores drain in FIFO order on idle cycles or when full.
module store_buffer
    import tessia_mem_pkg::*;
#(
    parameter int WIDTH = SB_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    input  logic [WIDTH-1:0] st_addr,
    input  logic [WIDTH-1:0] st_data,
    output logic             st_ready,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_addr,
    output logic [WIDTH-1:0] ld_data,
    output logic             ld_stall,
    output logic             sb_empty,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);

    sb_entry_t        entry_q [DEPTH];
    sb_entry_t        entry_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             full;
    logic             empty;
    logic             enq;
    logic             drain;
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;

    logic [DEPTH-1:0][WIDTH-1:0] ent_addr;
    logic [DEPTH-1:0][WIDTH-1:0] ent_data;

    always_comb begin
        ent_addr = '0;
        ent_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] = entry_q[i].addr;
            ent_data[i] = entry_q[i].data;
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .head     (head_q),
        .count    (count_q),
        .ld_addr  (ld_addr),
        .hit      (fwd_hit),
        .data     (fwd_data)
    );

    // Drain is suppressed during reset so dropped entries never reach memory.
    always_comb begin
        full     = (count_q == FULL_COUNT);
        empty    = (count_q == '0);
        st_ready = !full;
        sb_empty = empty;
        enq      = st_valid && !full;
        drain    = !rst && (full || (!ld_valid && !empty));
        ld_stall = full && ld_valid;
        mem_we   = drain;
        mem_a    = ld_addr;
        mem_wd   = '0;
        if (drain) begin
            mem_a  = entry_q[head_q].addr;
            mem_wd = entry_q[head_q].data;
        end
        ld_data = fwd_hit ? fwd_data : mem_rd;
    end

    always_comb begin
        entry_d = entry_q;
        if (enq) begin
            entry_d[tail_q] = '{addr: st_addr, data: st_data};
        end
        head_d  = head_q + PTR_W'(drain);
        tail_d  = tail_q + PTR_W'(enq);
        count_d = count_q + (PTR_W + 1)'(enq) - (PTR_W + 1)'(drain);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads need no reset; only slots below count are ever observed.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule
